// File: rtl/pwm_csr_bank.sv
// pwm_csr_bank: decodes framed SPI command bytes into register reads and
// writes on a bank of N_CH PWM channels. Each channel has double-buffered
// duty/period registers (shadow written by SPI, active used by the counter)
// and an immediate control register (bit0 enable, bit1 invert).
module pwm_csr_bank #(
    parameter int N_CH  = 4,
    parameter int PWM_W = 16
) (
    input  logic            sys_clk,
    input  logic            rst,
    input  logic            frame_en,
    input  logic [7:0]      data_in,
    input  logic            data_rdy,
    output logic [7:0]      data_out,
    output logic            data_latch,
    output logic            busy,
    output logic [N_CH-1:0] pwm_out
);

    localparam int BYTES = (PWM_W + 7) / 8;
    localparam int AW    = BYTES * 8;
    localparam int CW    = $clog2(BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic            cmd_wr_reg, cmd_wr_next;
    logic [4:0]      cmd_ch_reg, cmd_ch_next;
    logic [1:0]      cmd_sel_reg, cmd_sel_next;
    logic [CW-1:0]   byte_cnt_reg, byte_cnt_next, byte_cnt_inc;
    logic [AW-1:0]   asm_reg, asm_next;
    logic [AW-1:0]   rd_shift_reg, rd_shift_next;
    logic            commit_reg, commit_next;
    logic [7:0]      data_out_reg, data_out_next;
    logic            data_latch_reg, data_latch_next;
    logic            cmd_legal;
    logic [AW-1:0]   rd_word;
    logic [PWM_W-1:0] wr_val;

    // Per-channel shadow/control values exported for read-back
    logic [PWM_W-1:0] duty_sh_w   [N_CH];
    logic [PWM_W-1:0] period_sh_w [N_CH];
    logic [1:0]       ctrl_w      [N_CH];

    assign cmd_legal    = (int'(cmd_ch_reg) < N_CH) && (cmd_sel_reg != 2'd3);
    assign byte_cnt_inc = byte_cnt_reg + 1'b1;
    assign wr_val       = asm_reg[PWM_W-1:0];

    // Read-back word for the command byte currently on data_in; zero for illegal accesses
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (data_in[6:2] == 5'(i)) begin
                case (data_in[1:0])
                    2'd0:    rd_word[PWM_W-1:0] = duty_sh_w[i];
                    2'd1:    rd_word[PWM_W-1:0] = period_sh_w[i];
                    2'd2:    rd_word[1:0]       = ctrl_w[i];
                    default: rd_word            = '0;
                endcase
            end
        end
    end

    // Frame FSM: next state, byte assembly, read shifting and commit strobe
    always_comb begin
        state_next      = state_reg;
        cmd_wr_next     = cmd_wr_reg;
        cmd_ch_next     = cmd_ch_reg;
        cmd_sel_next    = cmd_sel_reg;
        byte_cnt_next   = byte_cnt_reg;
        asm_next        = asm_reg;
        rd_shift_next   = rd_shift_reg;
        data_out_next   = data_out_reg;
        data_latch_next = 1'b0;
        commit_next     = 1'b0;
        if (!frame_en) begin
            // Dropping chip-select abandons the frame; a partial write never commits
            state_next    = ST_IDLE;
            byte_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (data_rdy) begin
                        cmd_wr_next   = data_in[7];
                        cmd_ch_next   = data_in[6:2];
                        cmd_sel_next  = data_in[1:0];
                        byte_cnt_next = '0;
                        asm_next      = '0;
                        if (!data_in[7]) begin
                            // Snapshot the whole register so multi-byte reads are coherent
                            data_out_next   = rd_word[AW-1 -: 8];
                            rd_shift_next   = rd_word << 8;
                            data_latch_next = 1'b1;
                            state_next      = (BYTES == 1) ? ST_DONE : ST_DATA;
                        end else begin
                            state_next = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (data_rdy) begin
                        if (cmd_wr_reg) begin
                            asm_next = (asm_reg << 8) | AW'(data_in);
                            if (byte_cnt_reg == CW'(BYTES - 1)) begin
                                commit_next = cmd_legal;
                                state_next  = ST_DONE;
                            end else begin
                                byte_cnt_next = byte_cnt_inc;
                            end
                        end else begin
                            data_out_next   = rd_shift_reg[AW-1 -: 8];
                            rd_shift_next   = rd_shift_reg << 8;
                            data_latch_next = 1'b1;
                            byte_cnt_next   = byte_cnt_inc;
                            if (byte_cnt_inc == CW'(BYTES - 1)) begin
                                state_next = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (data_rdy && !cmd_wr_reg) begin
                        data_out_next   = 8'h00;
                        data_latch_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cmd_wr_reg     <= 1'b0;
            cmd_ch_reg     <= '0;
            cmd_sel_reg    <= '0;
            byte_cnt_reg   <= '0;
            asm_reg        <= '0;
            rd_shift_reg   <= '0;
            commit_reg     <= 1'b0;
            data_out_reg   <= 8'h00;
            data_latch_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cmd_wr_reg     <= cmd_wr_next;
            cmd_ch_reg     <= cmd_ch_next;
            cmd_sel_reg    <= cmd_sel_next;
            byte_cnt_reg   <= byte_cnt_next;
            asm_reg        <= asm_next;
            rd_shift_reg   <= rd_shift_next;
            commit_reg     <= commit_next;
            data_out_reg   <= data_out_next;
            data_latch_reg <= data_latch_next;
        end
    end

    assign data_out   = data_out_reg;
    assign data_latch = data_latch_reg;
    assign busy       = (state_reg != ST_IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [PWM_W-1:0] duty_sh_reg, duty_sh_next;
            logic [PWM_W-1:0] period_sh_reg, period_sh_next;
            logic [PWM_W-1:0] duty_act_reg, period_act_reg, cnt_reg;
            logic [1:0]       ctrl_reg, ctrl_next;
            logic             pwm_reg;
            logic             hit;

            assign hit = commit_reg && (cmd_ch_reg == 5'(gi));

            // Shadow and control update on commit; *_next feed the active load so a
            // commit coinciding with a wrap is picked up immediately
            always_comb begin
                duty_sh_next   = duty_sh_reg;
                period_sh_next = period_sh_reg;
                ctrl_next      = ctrl_reg;
                if (hit) begin
                    case (cmd_sel_reg)
                        2'd0:    duty_sh_next   = wr_val;
                        2'd1:    period_sh_next = wr_val;
                        2'd2:    ctrl_next      = wr_val[1:0];
                        default: ctrl_next      = ctrl_reg;
                    endcase
                end
            end

            // Counter, active-register reload at wrap (or every cycle when disabled) and registered output
            always_ff @(posedge sys_clk or negedge rst) begin
                if (!rst) begin
                    duty_sh_reg    <= '0;
                    period_sh_reg  <= '1;
                    ctrl_reg       <= 2'b00;
                    duty_act_reg   <= '0;
                    period_act_reg <= '1;
                    cnt_reg        <= '0;
                    pwm_reg        <= 1'b0;
                end else begin
                    duty_sh_reg   <= duty_sh_next;
                    period_sh_reg <= period_sh_next;
                    ctrl_reg      <= ctrl_next;
                    if (!ctrl_reg[0]) begin
                        cnt_reg        <= '0;
                        duty_act_reg   <= duty_sh_next;
                        period_act_reg <= period_sh_next;
                        pwm_reg        <= ctrl_reg[1];
                    end else begin
                        pwm_reg <= (cnt_reg < duty_act_reg) ^ ctrl_reg[1];
                        if (cnt_reg == period_act_reg) begin
                            cnt_reg        <= '0;
                            duty_act_reg   <= duty_sh_next;
                            period_act_reg <= period_sh_next;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            end

            assign duty_sh_w[gi]   = duty_sh_reg;
            assign period_sh_w[gi] = period_sh_reg;
            assign ctrl_w[gi]      = ctrl_reg;
            assign pwm_out[gi]     = pwm_reg;
        end
    endgenerate

endmodule

// File: doc/pwm_csr_bank.md
Name: pwm_csr_bank

Overview:
Parametrised control/status block that decodes a framed SPI byte stream into read/write accesses to a bank of N_CH PWM channels. Each channel has its own counter and double-buffered duty and period registers, plus a control register. It sits between the SPI byte interface and the chip PWM pins. It is the multi-channel, read-back-capable successor of the single-channel CSR/PWM pair.

Parameters:
N_CH, 4, number of PWM channels (1..32)
PWM_W, 16, width of the duty, period and counter registers (8..32); BYTES = (PWM_W+7)/8 bytes per register

Ports:
sys_clk  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-low reset
frame_en  in  1  high while an SPI frame is active (CS asserted)
data_in  in  8  received byte, valid when data_rdy=1
data_rdy  in  1  one-cycle strobe per received byte, synchronous to sys_clk
data_out  out  8  byte to shift out on the next SPI byte
data_latch  out  1  one-cycle pulse when data_out has been updated
busy  out  1  high while a frame's command is in progress
pwm_out  out  N_CH  PWM outputs; bit i belongs to channel i

Behaviour:
- Reset (rst=0, asynchronous) sets the following values:
  - data_out=0x00, data_latch=0, busy=0, pwm_out=0, FSM=IDLE.
  - All counters=0; all shadow and active duty registers=0.
  - Shadow and active period registers = all ones; ctrl=0.
- Command byte format:
  - bit7 = 1 for write, 0 for read.
  - bits[6:2] = channel.
  - bits[1:0] = register: 0 DUTY, 1 PERIOD, 2 CTRL (bit0 enable, bit1 invert), 3 reserved.
- Register data: BYTES bytes, MSB first. Upper bits beyond PWM_W in the first byte are ignored on write and read as 0.
- FSM states:
  - IDLE: the first data_rdy with frame_en=1 latches the command and moves to DATA. busy=1 from the next cycle.
  - DATA: counts bytes 0..BYTES-1.
    - Write: bytes shift into an assembly register. The last byte commits to the shadow register on the next cycle, then the FSM moves to DONE.
    - Read: data_out is loaded with byte 0 one cycle after the command's data_rdy, and data_latch pulses. Each further data_rdy loads the next byte after 1 cycle, with a data_latch pulse. After byte BYTES-1 has been loaded, the FSM moves to DONE.
  - DONE: extra bytes are ignored for writes. For reads, each extra byte sets data_out=0x00 with a data_latch pulse.
  - Any state, frame_en=0: return to IDLE next cycle, busy=0, and discard any partial write (shadow unchanged). frame_en=0 overrides a data_rdy in the same cycle.
- Illegal access (channel >= N_CH or register 3): the FSM sequences normally, writes are discarded, reads return 0x00 bytes.
- CTRL writes take effect on commit, with no double buffering.
- PWM channel i:
  - Enabled: cnt counts 0..period_act inclusive, giving a period of period_act+1 clocks.
  - At cnt==period_act: cnt wraps to 0, and duty_act/period_act load from shadow. If a commit occurs in the same cycle as the wrap, the newly committed value is loaded.
  - raw = (cnt < duty_act). duty_act > period_act gives a constant 1; duty_act=0 gives a constant 0. period_act=0 gives a 1-clock period.
  - pwm_out[i] = raw XOR invert when enabled. When disabled, pwm_out[i] = invert and cnt is held at 0.
  - Disabled channels load active registers from shadow every cycle.
  - pwm_out is registered: 1 cycle after cnt.
- Reset mid-frame: everything returns immediately to the reset values above.

Test Plan:
- Reset: hold rst=0 with traffic on data_in/data_rdy -> data_out=0x00, pwm_out=0, busy=0; after release, read ch0 PERIOD returns 0xFF,0xFF.
- Write ch1 PERIOD=9, DUTY=3, CTRL=0x01 (bytes 0x85,0x00,0x09 / 0x84,0x00,0x03 / 0x86,0x00,0x01) -> pwm_out[1] high 3 clocks, low 7 clocks, repeating with period 10.
- Double buffering: write DUTY=7 on ch1 mid-period -> current period keeps duty 3; the first period after the wrap shows 7 high clocks.
- Read back: after the writes above, frame 0x05,dummy,dummy -> data_out sequence 0x00 then 0x09, each with a one-cycle data_latch pulse; a further byte yields 0x00.
- Aborted write: 0x84,0x00 then frame_en=0 -> DUTY unchanged, busy=0, the next frame decodes from its command byte.
- Edge cases:
  - ch3 CTRL=0x03 with DUTY=0 -> constant 1.
  - DUTY=12 > PERIOD=9 on ch1 -> constant 1.
  - Command 0xFC (ch31, N_CH=4) -> ignored.
  - Read 0x7C -> data_out 0x00 for all bytes.
